// File: rtl/chaos_xor_diffuser_pkg.sv
// chaos_xor_diffuser_pkg
//   Shared definitions for the chaotic key diffuser: FP32 field layout,
//   exponent bounds for the key conversion, saturation key values, the
//   control FSM state encoding and the byte-folding helper.
package chaos_xor_diffuser_pkg;

  // FP32 field layout
  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;

  // Exponent bounds: [EXP_MIN_FRAC, EXP_MAX_FRAC] gives a nonzero Q0.32
  // fraction, EXP_ONE and above means the sample is >= 1.0.
  localparam logic [EXP_W-1:0] EXP_MIN_FRAC = 8'd95;
  localparam logic [EXP_W-1:0] EXP_MAX_FRAC = 8'd126;
  localparam logic [EXP_W-1:0] EXP_ONE      = 8'd127;

  // Saturation keys
  localparam logic [7:0] KEY_UNDERFLOW = 8'h00;
  localparam logic [7:0] KEY_SATURATE  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // XOR-fold a 32-bit fraction down to one key byte.
  function automatic logic [7:0] fold_bytes(input logic [FP_W-1:0] f);
    return f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
  endfunction

endpackage

// File: rtl/chaos_xor_diffuser_keybyte.sv
// fp_to_keybyte
//   Combinational conversion of one FP32 chaotic sample into a key byte.
//   Ports:
//     fp_in     - IEEE-754 single sample, expected in [0,1)
//     key_out   - folded key byte (00 for tiny values, FF when out of range)
//     range_err - high when the sample is negative or >= 1.0 (incl. Inf/NaN)
module fp_to_keybyte
  import chaos_xor_diffuser_pkg::*;
(
  input  logic [FP_W-1:0] fp_in,
  output logic [7:0]      key_out,
  output logic            range_err
);

  logic             sign_bit;
  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;
  logic [EXP_W-1:0] shift_full;
  logic [FP_W-1:0]  frac;

  always_comb begin
    sign_bit   = fp_in[SIGN_POS];
    exp_field  = fp_in[EXP_MSB:EXP_LSB];
    man_field  = fp_in[MAN_W-1:0];
    shift_full = '0;
    frac       = '0;
    key_out    = KEY_UNDERFLOW;
    range_err  = 1'b0;

    if (sign_bit || (exp_field >= EXP_ONE)) begin
      key_out   = KEY_SATURATE;
      range_err = 1'b1;
    end else if (exp_field >= EXP_MIN_FRAC) begin
      // Exponent is in 95..126, so the shift is 0..31 and fits in 5 bits.
      shift_full = EXP_MAX_FRAC - exp_field;
      frac       = {1'b1, man_field, 8'b0} >> shift_full[4:0];
      key_out    = fold_bytes(frac);
    end
  end

endmodule

// File: rtl/chaos_xor_diffuser.sv
// chaos_xor_diffuser
//   Turns FP32 chaotic samples into key bytes, buffers them in a 2-entry
//   FIFO and XORs them with a pixel stream using ciphertext chaining.
//   Ports:
//     clk, reset          - clock, asynchronous active-high reset
//     start, decrypt      - frame start pulse and mode (sampled on start)
//     chaos_in/valid/ready- key sample stream (accepted in any state)
//     pix_in/valid/ready  - input byte stream
//     pix_out/out_valid/out_ready - registered output byte stream
//     done                - one-cycle pulse after the last byte is accepted
//     range_err           - sticky out-of-range sample flag, cleared on start
module chaos_xor_diffuser
  import chaos_xor_diffuser_pkg::*;
#(
  parameter int         FRAME_PIXELS = 16,
  parameter logic [7:0] IV           = 8'h5A
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            decrypt,
  input  logic [FP_W-1:0] chaos_in,
  input  logic            chaos_valid,
  output logic            chaos_ready,
  input  logic [7:0]      pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [7:0]      pix_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            done,
  output logic            range_err
);

  localparam int              CNT_W    = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  // Key conversion
  logic [7:0] key_byte;
  logic       key_range;

  fp_to_keybyte u_keybyte (
    .fp_in     (chaos_in),
    .key_out   (key_byte),
    .range_err (key_range)
  );

  // State
  state_e           state_q, state_d;
  logic             decrypt_q, decrypt_d;
  logic [7:0]       prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       pix_out_q, pix_out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             range_err_q, range_err_d;

  logic [7:0]       fifo_mem_q [2];
  logic [7:0]       fifo_mem_d [2];
  logic             fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic             fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;

  // Handshakes
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       push;
  logic       pix_fire;
  logic       out_accept;
  logic [7:0] xor_byte;
  logic       range_clear;

  assign fifo_full  = (fifo_cnt_q == 2'd2);
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign fifo_head  = fifo_mem_q[fifo_rd_ptr_q];

  // Keys are accepted in every state so they can prefetch while idle.
  assign chaos_ready = !fifo_full;
  assign push        = chaos_valid && !fifo_full;

  assign out_accept = out_valid_q && out_ready;
  // A new byte may enter only if the output slot is free or draining now.
  assign pix_ready  = (state_q == ST_RUN) && !fifo_empty && (!out_valid_q || out_ready);
  assign pix_fire   = pix_valid && pix_ready;

  // Encrypt and decrypt share the same XOR; only the chaining source differs.
  assign xor_byte = pix_in ^ fifo_head ^ prev_q;

  // FIFO next state
  always_comb begin
    fifo_mem_d    = fifo_mem_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    if (push) begin
      fifo_mem_d[fifo_wr_ptr_q] = key_byte;
      fifo_wr_ptr_d             = !fifo_wr_ptr_q;
    end
    // pix_fire already implies the FIFO is not empty.
    if (pix_fire) begin
      fifo_rd_ptr_d = !fifo_rd_ptr_q;
    end
    case ({push, pix_fire})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control and datapath next state
  always_comb begin
    state_d     = state_q;
    decrypt_d   = decrypt_q;
    prev_d      = prev_q;
    count_d     = count_q;
    pix_out_d   = pix_out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    range_clear = 1'b0;

    // Accepted byte leaves the slot; a load below overrides this.
    if (out_accept) begin
      out_valid_d = 1'b0;
      pix_out_d   = 8'h00;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          decrypt_d   = decrypt;
          prev_d      = IV;
          count_d     = '0;
          range_clear = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pix_fire) begin
          pix_out_d   = xor_byte;
          out_valid_d = 1'b1;
          // Chaining always follows the ciphertext side.
          prev_d      = decrypt_q ? pix_in : xor_byte;
          count_d     = count_q + CNT_W'(1);
          if (count_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_accept) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bad sample pushed in the start cycle still registers.
    range_err_d = (range_clear ? 1'b0 : range_err_q) | (push && key_range);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      decrypt_q     <= 1'b0;
      prev_q        <= IV;
      count_q       <= '0;
      pix_out_q     <= 8'h00;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      range_err_q   <= 1'b0;
      fifo_mem_q[0] <= 8'h00;
      fifo_mem_q[1] <= 8'h00;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      decrypt_q     <= decrypt_d;
      prev_q        <= prev_d;
      count_q       <= count_d;
      pix_out_q     <= pix_out_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
      range_err_q   <= range_err_d;
      fifo_mem_q    <= fifo_mem_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  assign pix_out   = pix_out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_chaos_xor_diffuser.sv
// tb_chaos_xor_diffuser
//   Directed bench for chaos_xor_diffuser with FRAME_PIXELS=2, IV=5A.
//   Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_chaos_xor_diffuser;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        decrypt;
  logic [31:0] chaos_in;
  logic        chaos_valid;
  logic        chaos_ready;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_out;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        range_err;

  logic [31:0] kc_in;
  logic [7:0]  kc_key;
  logic        kc_rng;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  chaos_xor_diffuser #(
    .FRAME_PIXELS (2),
    .IV           (8'h5A)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .decrypt     (decrypt),
    .chaos_in    (chaos_in),
    .chaos_valid (chaos_valid),
    .chaos_ready (chaos_ready),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_out     (pix_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done),
    .range_err   (range_err)
  );

  fp_to_keybyte u_kc (
    .fp_in     (kc_in),
    .key_out   (kc_key),
    .range_err (kc_rng)
  );

  task automatic drive_key(input logic [31:0] v);
    @(negedge clk); chaos_valid = 1'b1; chaos_in = v;
    @(negedge clk); chaos_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (pix_out !== 8'h00)   begin miscompares++; $display("FAIL reset_pix_out: got %h expected 00", pix_out); end
    vectors++; if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (pix_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
    vectors++; if (chaos_ready !== 1'b1) begin miscompares++; $display("FAIL reset_chaos_ready: got %b expected 1", chaos_ready); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (range_err !== 1'b0)  begin miscompares++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
    reset = 1'b0;
    $display("reset: outputs at reset values checked");
  endtask

  task automatic test_key_conv;
    logic [31:0] vin [7];
    logic [7:0]  vkey [7];
    logic        vrng [7];
    vin[0] = 32'h3F400000; vkey[0] = 8'hC0; vrng[0] = 1'b0; // 0.75
    vin[1] = 32'h3DCCCCCD; vkey[1] = 8'hB9; vrng[1] = 1'b0; // 0.1
    vin[2] = 32'h00000000; vkey[2] = 8'h00; vrng[2] = 1'b0; // zero
    vin[3] = 32'h3F800000; vkey[3] = 8'hFF; vrng[3] = 1'b1; // 1.0
    vin[4] = 32'hBF000000; vkey[4] = 8'hFF; vrng[4] = 1'b1; // -0.5
    vin[5] = 32'h2F800000; vkey[5] = 8'h01; vrng[5] = 1'b0; // e=95, F=1
    vin[6] = 32'h2F000000; vkey[6] = 8'h00; vrng[6] = 1'b0; // e=94
    for (int i = 0; i < 7; i++) begin
      kc_in = vin[i];
      #1;
      vectors++;
      if (kc_key !== vkey[i] || kc_rng !== vrng[i]) begin
        miscompares++;
        $display("FAIL key_conv[%0d]: in %h got key %h rng %b expected key %h rng %b", i, vin[i], kc_key, kc_rng, vkey[i], vrng[i]);
      end
      $display("key_conv: in %h -> key %h rng %b", vin[i], kc_key, kc_rng);
    end
  endtask

  task automatic test_fifo_full;
    // Three samples offered back to back while idle; only two fit.
    @(negedge clk); chaos_valid = 1'b1; chaos_in = 32'h3F400000; #1;
    vectors++; if (chaos_ready !== 1'b1) begin miscompares++; $display("FAIL fifo_ready_0: got %b expected 1", chaos_ready); end
    @(negedge clk); chaos_in = 32'h3DCCCCCD; #1;
    vectors++; if (chaos_ready !== 1'b1) begin miscompares++; $display("FAIL fifo_ready_1: got %b expected 1", chaos_ready); end
    @(negedge clk); chaos_in = 32'h3F800000; #1;
    vectors++; if (chaos_ready !== 1'b0) begin miscompares++; $display("FAIL fifo_ready_full: got %b expected 0", chaos_ready); end
    @(negedge clk); #1;
    vectors++; if (chaos_ready !== 1'b0) begin miscompares++; $display("FAIL fifo_ready_hold: got %b expected 0", chaos_ready); end
    vectors++; if (range_err !== 1'b0)   begin miscompares++; $display("FAIL fifo_third_not_pushed: range_err got %b expected 0", range_err); end
    chaos_valid = 1'b0;
    $display("fifo_full: three offered, two accepted");
  endtask

  // Runs a 2-pixel frame assuming two keys are already queued.
  task automatic run_frame(input logic dec, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] e0, input logic [7:0] e1, input string tag);
    @(negedge clk); start = 1'b1; decrypt = dec; pix_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; pix_valid = 1'b1; pix_in = p0; #1;
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready0: got %b expected 1", tag, pix_ready); end
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL %s_range_clear: got %b expected 0", tag, range_err); end
    @(negedge clk); pix_in = p1; #1;
    vectors++; if (out_valid !== 1'b1 || pix_out !== e0) begin miscompares++; $display("FAIL %s_byte0: got %h/%b expected %h/1", tag, pix_out, out_valid, e0); end
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready1: got %b expected 1", tag, pix_ready); end
    $display("%s: in %h -> out %h", tag, p0, pix_out);
    @(negedge clk); pix_valid = 1'b0; #1;
    vectors++; if (out_valid !== 1'b1 || pix_out !== e1) begin miscompares++; $display("FAIL %s_byte1: got %h/%b expected %h/1", tag, pix_out, out_valid, e1); end
    vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL %s_drain_ready: got %b expected 0", tag, pix_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s_done_early: got %b expected 0", tag, done); end
    $display("%s: in %h -> out %h", tag, p1, pix_out);
    @(negedge clk); #1;
    vectors++; if (done !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_done: got done %b valid %b expected 1/0", tag, done, out_valid); end
    @(negedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s_done_pulse: got %b expected 0", tag, done); end
  endtask

  task automatic test_encrypt;
    run_frame(1'b0, 8'h12, 8'h34, 8'h88, 8'h05, "encrypt");
  endtask

  task automatic test_decrypt;
    drive_key(32'h3F400000);
    drive_key(32'h3DCCCCCD);
    run_frame(1'b1, 8'h88, 8'h05, 8'h12, 8'h34, "decrypt");
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL decrypt_range_err: got %b expected 0", range_err); end
  endtask

  task automatic test_backpressure;
    drive_key(32'h3F400000);
    drive_key(32'h3DCCCCCD);
    @(negedge clk); start = 1'b1; decrypt = 1'b0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; pix_valid = 1'b1; pix_in = 8'h12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_ready = 1'b0; pix_in = 8'h34; #1;
      vectors++; if (pix_out !== 8'h88 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d]: got %h/%b expected 88/1", i, pix_out, out_valid); end
      vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, pix_ready); end
      $display("backpressure: cycle %0d holding %h", i, pix_out);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL bp_resume_ready: got %b expected 1", pix_ready); end
    @(negedge clk); pix_valid = 1'b0; #1;
    vectors++; if (pix_out !== 8'h05 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resume_byte: got %h/%b expected 05/1", pix_out, out_valid); end
    $display("backpressure: resumed with %h", pix_out);
    @(negedge clk); #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done: got %b expected 1", done); end
  endtask

  task automatic test_starvation_range;
    @(negedge clk); start = 1'b1; decrypt = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; pix_valid = 1'b1; pix_in = 8'h11;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL starve_ready[%0d]: got %b expected 0", i, pix_ready); end
    end
    @(negedge clk); chaos_valid = 1'b1; chaos_in = 32'h3F800000; #1;
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL range_before: got %b expected 0", range_err); end
    @(negedge clk); chaos_in = 32'h00000000; #1;
    vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL range_set: got %b expected 1", range_err); end
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL starve_release: got %b expected 1", pix_ready); end
    @(negedge clk); chaos_valid = 1'b0; pix_valid = 1'b0; #1;
    vectors++; if (pix_out !== 8'hB4) begin miscompares++; $display("FAIL range_key_ff: got %h expected b4", pix_out); end
    $display("starvation: in 11 -> out %h with saturated key", pix_out);
    drive_key(32'h3F400000);
    #1;
    vectors++; if (chaos_ready !== 1'b0) begin miscompares++; $display("FAIL run_fifo_full: got %b expected 0", chaos_ready); end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk); reset = 1'b1; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (pix_out !== 8'h00) begin miscompares++; $display("FAIL midrst_pix_out: got %h expected 00", pix_out); end
    vectors++; if (chaos_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_chaos_ready: got %b expected 1", chaos_ready); end
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL midrst_range_err: got %b expected 0", range_err); end
    @(negedge clk); reset = 1'b0;
    $display("reset mid-run applied");
  endtask

  task automatic test_start_clears;
    drive_key(32'h3F800000);
    drive_key(32'h3F400000);
    #1;
    vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL idle_range_set: got %b expected 1", range_err); end
    // Stale keys from before the reset would give 5A first instead of A5.
    run_frame(1'b0, 8'h00, 8'h00, 8'hA5, 8'h65, "post_reset");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; decrypt = 1'b0; chaos_in = '0; chaos_valid = 1'b0;
    pix_in = '0; pix_valid = 1'b0; out_ready = 1'b0; kc_in = '0;
    test_reset();
    test_key_conv();
    test_fifo_full();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_starvation_range();
    test_reset_mid_run();
    test_start_clears();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chaos_xor_diffuser.md
# chaos_xor_diffuser

Downstream consumer of the sawtooth chaotic-map stage in the image-encryption datapath. It converts each FP32 chaotic sample into an 8-bit key byte, buffers key bytes in a 2-entry FIFO, and combines them with a streamed pixel byte using XOR plus ciphertext chaining (diffusion). The same block performs encryption or decryption, selected per frame. It sits between the sawtooth map output and the image/pixel output interface.

## Interface
- `FRAME_PIXELS`, default 16, number of pixels per frame (≥1).
- `IV`, default 8'h5A, initial chaining byte loaded at frame start.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a frame (honoured in IDLE only).
- `decrypt` in 1: 0 = encrypt, 1 = decrypt; sampled on accepted `start`.
- `chaos_in` in 32: IEEE-754 single sample from the sawtooth stage, expected in [0,1).
- `chaos_valid` in 1: `chaos_in` is valid.
- `chaos_ready` out 1: key FIFO can accept a sample.
- `pix_in` in 8: input byte (plain when encrypting, cipher when decrypting).
- `pix_valid` in 1, `pix_ready` out 1: input handshake.
- `pix_out` out 8, `out_valid` out 1, `out_ready` in 1: output handshake.
- `done` out 1: one-cycle pulse when the frame's last byte is accepted downstream.
- `range_err` out 1: sticky; a sample was outside [0,1).

## Operation
- Key conversion (combinational, on FIFO write), fields s, e, m of `chaos_in`:
  - e in 95..126 and s=0: F = ({1,m,8'b0}) >> (126−e), a 32-bit Q0.32 fraction; key = F[31:24]^F[23:16]^F[15:8]^F[7:0].
  - e < 95 (incl. zero/denormal): key = 8'h00.
  - s=1 or e ≥ 127 (incl. Inf/NaN): key = 8'hFF; set `range_err`.
- Key FIFO: depth 2. Push on `chaos_valid && chaos_ready`; `chaos_ready = !full`, independent of state, so keys prefetch in IDLE. No push-when-full bypass. Pop only on a pixel handshake.
- FSM states:
  - IDLE: on `start`, latch `decrypt`, set prev = IV, clear count and `range_err`, then go to RUN.
  - RUN: `pix_ready = !fifo_empty && (!out_valid || out_ready)`. On a pixel handshake, with k = FIFO head:
    - encrypt: c = p ^ k ^ prev; prev ← c; `pix_out` ← c.
    - decrypt: p = c_in ^ k ^ prev; prev ← c_in; `pix_out` ← p.
    - Then pop the FIFO and increment count. After handshake number FRAME_PIXELS, go to DRAIN.
  - DRAIN: `pix_ready`=0; when `out_valid && out_ready`, pulse `done` and go to IDLE.
- `start` outside IDLE is ignored. Once FRAME_PIXELS is reached, further pixels stall.

## Timing
- Reset values: `pix_out`=0, `out_valid`=0, `pix_ready`=0, `chaos_ready`=1, `done`=0, `range_err`=0; FIFO empty; state IDLE; prev=IV.
- Latency: `pix_out` and `out_valid` are registered, 1 cycle after the pixel handshake.
- Throughput: 1 byte/cycle with `out_ready` held high and keys supplied ≥1/cycle.
- Output register: holds value and `out_valid` while `out_ready`=0. It is cleared on acceptance unless a new byte is loaded in the same cycle.
- FIFO: simultaneous push and pop when not full keeps occupancy unchanged. Pop is never issued when empty.
- `range_err` rises the cycle after the offending push.
- Reset mid-frame: everything returns to reset values immediately; partial output is discarded.

## Structure
- Shared package: FP32 field widths and positions, exponent bounds (95, 126, 127), saturation keys 8'h00/8'hFF, and the FSM state enum (IDLE, RUN, DRAIN).
- Sub-module `fp_to_keybyte`: combinational conversion producing key and range flag. It is reused by a future key-stream tap.
- FIFO and FSM are inline in the top.

## Test plan
- Key conversion: `chaos_in`=32'h3F400000 (0.75) → key 8'hC0; 32'h3DCCCCCD (0.1) → 8'hB9; 32'h00000000 → 8'h00.
- Encrypt frame (FRAME_PIXELS=2, IV=5A): keys C0,B9, pixels 12,34 → `pix_out` 88 then 05, `done` pulse after 2nd accept.
- Decrypt same keys, pixels 88,05 → 12,34; then `range_err` stays 0.
- Backpressure: `out_ready`=0 for 3 cycles after first byte → `pix_out` holds 88, `pix_ready`=0, no FIFO pop. Resume → 05 next cycle.
- Key starvation and FIFO full:
  - No `chaos_valid` → `pix_ready`=0.
  - 3 samples pushed in IDLE → `chaos_ready` falls after 2.
- Range and reset:
  - 32'h3F800000 (1.0) → key FF, `range_err`=1.
  - `reset` asserted mid-RUN → `out_valid`=0, FIFO empty, IDLE.
  - Next `start` clears `range_err`.
